// File: rtl/fifo_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter_if
//
// Bundles the producer-side request bus and the FIFO write port that the
// round-robin write arbiter sits between.
//
// Parameters:
//   NUM_REQ   number of producers sharing the FIFO write port
//   WIDTH     FIFO word width
//
// Signals:
//   req       per-producer "word valid"
//   req_data  producer i's word at [i*WIDTH +: WIDTH]
//   fifo_full backpressure from the FIFO write side
//   grant     registered one-hot (or zero) burst owner
//   accept    per-producer "word consumed this cycle" (combinational)
//   write_en  FIFO write strobe
//   data_in   FIFO write data
//   busy      registered, high while a burst is owned
//
// Modports:
//   master    the environment: producers plus the FIFO full flag
//   slave     the arbiter itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface fifo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic                     fifo_full;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       accept;
    logic                     write_en;
    logic [WIDTH-1:0]         data_in;
    logic                     busy;

    modport master (
        output req,
        output req_data,
        output fifo_full,
        input  grant,
        input  accept,
        input  write_en,
        input  data_in,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
        input  fifo_full,
        output grant,
        output accept,
        output write_en,
        output data_in,
        output busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter that shares the single write port of the clock-domain
// crossing FIFO between NUM_REQ producers, all in the write clock domain.
// A grant is a burst of up to BURST_LEN words; FIFO-full backpressure freezes
// the burst (no timeout, no preemption). The owner of the burst that just
// ended has the lowest priority for the next pick.
//
// Parameters:
//   NUM_REQ    number of requesters (>= 2)
//   WIDTH      data width, equal to the FIFO width
//   BURST_LEN  maximum words per grant (>= 1)
//
// Ports:
//   clk_write     write-domain clock, all state on the rising edge
//   rst           synchronous active-high reset
//   bus           fifo_write_arbiter_if.slave: req, req_data, fifo_full in;
//                 grant, accept, write_en, data_in, busy out
//   stall_cycles  16-bit saturating count of cycles in which the owner had a
//                 word ready but the FIFO was full; only present when the
//                 macro FIFO_ARB_STATS_EN is defined
//
// Optional feature: define FIFO_ARB_STATS_EN to add the stall_cycles counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk_write,
    input  logic                 rst,
    fifo_write_arbiter_if.slave  bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]          stall_cycles
`endif
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int IW = OW + 1;
    localparam int CW = $clog2(BURST_LEN) + 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(BURST_LEN - 1);
    localparam logic [OW-1:0] OWNER_LAST = OW'(NUM_REQ - 1);
    localparam logic [IW-1:0] IDX_WRAP   = IW'(NUM_REQ);

    generate
        if (NUM_REQ < 2) begin : g_bad_num_req
            $error("fifo_write_arbiter: NUM_REQ must be at least 2");
        end
        if (BURST_LEN < 1) begin : g_bad_burst_len
            $error("fifo_write_arbiter: BURST_LEN must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Registered state
    state_t             state;
    logic [OW-1:0]      owner;
    logic [OW-1:0]      last_owner;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] grant;
    logic               busy;

    // Next-state values
    state_t             state_nxt;
    logic [OW-1:0]      owner_nxt;
    logic [OW-1:0]      last_owner_nxt;
    logic [CW-1:0]      cnt_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               busy_nxt;

    // Combinational helpers
    logic [OW-1:0]      pick;
    logic               pick_vld;
    logic [IW-1:0]      rr_idx;
    logic               owner_req;
    logic [NUM_REQ-1:0] accept;
    logic               write_en;
    logic               burst_done;
    logic [WIDTH-1:0]   words [NUM_REQ];
    logic [WIDTH-1:0]   data_in;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Split the flat request data bus into one word per requester.
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_words
            assign words[g] = bus.req_data[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting just after last_owner. The offset runs
    // 1..NUM_REQ, so the previous owner is examined last and still wins when
    // it is the only requester left. One conditional subtraction is enough
    // for the wrap because the sum never reaches 2*NUM_REQ.
    always_comb begin
        pick     = last_owner;
        pick_vld = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = {1'b0, last_owner} + IW'(k);
            if (rr_idx >= IDX_WRAP) begin
                rr_idx = rr_idx - IDX_WRAP;
            end
            if (!pick_vld && bus.req[rr_idx[OW-1:0]]) begin
                pick     = rr_idx[OW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Word transfer happens in the same cycle the owner presents a word and
    // the FIFO has room; grant is zero outside a burst so accept is too.
    assign owner_req  = bus.req[owner];
    assign accept     = grant & bus.req & {NUM_REQ{~bus.fifo_full}};
    assign write_en   = |accept;

    // A dropped request ends the burst even while the FIFO is full; only a
    // still-requesting owner is frozen by backpressure.
    assign burst_done = (write_en && (cnt == CNT_LAST)) || !owner_req;

    // Next-state and registered-output decode
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt      = BURST;
                    owner_nxt      = pick;
                    last_owner_nxt = pick;
                    cnt_nxt        = '0;
                end
            end

            BURST: begin
                if (write_en) begin
                    cnt_nxt = cnt + CW'(1);
                end
                if (burst_done) begin
                    if (pick_vld) begin
                        // Back-to-back handover, no idle cycle.
                        owner_nxt      = pick;
                        last_owner_nxt = pick;
                        cnt_nxt        = '0;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        grant_nxt = (state_nxt == BURST) ? onehot(owner_nxt) : '0;
        busy_nxt  = (state_nxt == BURST);
    end

    always_ff @(posedge clk_write) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OWNER_LAST;
            cnt        <= '0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
            grant      <= grant_nxt;
            busy       <= busy_nxt;
        end
    end

    // The owner's word is steered to the FIFO for the whole burst, so data_in
    // is stable while the FIFO is full; it is forced to zero when idle.
    assign data_in = (state == BURST) ? words[owner] : '0;

    assign bus.grant    = grant;
    assign bus.accept   = accept;
    assign bus.write_en = write_en;
    assign bus.data_in  = data_in;
    assign bus.busy     = busy;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counts cycles in which the owner is ready but blocked by the FIFO.
    always_ff @(posedge clk_write) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (busy && owner_req && bus.fifo_full) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
`timescale 1ns/1ps

module tb_fifo_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int DW        = NUM_REQ * WIDTH;

    logic clk_write = 1'b0;
    logic rst;

    always #5 clk_write = ~clk_write;

    fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cycles;
`endif

    fifo_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk_write (clk_write),
        .rst       (rst),
        .bus       (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Producers: each holds a queue of pending words; req is "queue non-empty
    // and enabled", the front word is presented and popped on acceptance.
    logic [WIDTH-1:0]   src_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] req_en;
    logic               full_in;
    logic [NUM_REQ-1:0] drv_req;
    logic [WIDTH-1:0]   drv_word [NUM_REQ];

    // Reference model: owner (-1 when idle), the owner that most recently won,
    // words still allowed in the current burst, and the stall statistic.
    int m_own;
    int m_last;
    int m_left;
    int m_stall;

    typedef struct {
        int               cyc;
        int               who;
        logic [WIDTH-1:0] d;
    } wr_t;

    wr_t                wr_log [$];
    logic [NUM_REQ-1:0] grant_log [$];
    logic [NUM_REQ-1:0] prev_grant;

    logic [WIDTH-1:0]   sb_exp [5];
    logic [NUM_REQ-1:0] fair_exp [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [NUM_REQ-1:0] v, input int i);
        logic [NUM_REQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int m_pick(input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (bit_of(r, (m_last + k) % NUM_REQ)) return (m_last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic m_start(input int p);
        m_own  = p;
        m_last = p;
        m_left = BURST_LEN;
    endtask

    task automatic model_update(input bit r, input logic [NUM_REQ-1:0] rq, input bit full);
        int p;
        bit own_req;
        if (r) begin
            m_own   = -1;
            m_last  = NUM_REQ - 1;
            m_left  = 0;
            m_stall = 0;
        end else if (m_own < 0) begin
            p = m_pick(rq);
            if (p >= 0) m_start(p);
        end else begin
            own_req = bit_of(rq, m_own);
            if (own_req && full && m_stall < 65535) m_stall++;
            if (own_req && !full) m_left--;
            if (!own_req || m_left == 0) begin
                p = m_pick(rq);
                if (p >= 0) m_start(p);
                else m_own = -1;
            end
        end
    endtask

    task automatic drive();
        logic [NUM_REQ-1:0] r;
        logic [DW-1:0]      d;
        r = '0;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_word[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            if (bit_of(req_en, i) && src_q[i].size() > 0) r = r | (NUM_REQ'(1) << i);
            d = d | (DW'(drv_word[i]) << (i * WIDTH));
        end
        drv_req       = r;
        bus.req       = r;
        bus.req_data  = d;
        bus.fifo_full = full_in;
    endtask

    // One clock: apply inputs after the falling edge, check, then let the
    // rising edge advance producers and model.
    task automatic tick();
        logic [NUM_REQ-1:0] e_grant;
        logic [NUM_REQ-1:0] e_acc;
        logic [WIDTH-1:0]   e_data;
        int                 who;
        drive();
        #1;
        e_grant = (m_own >= 0) ? (NUM_REQ'(1) << m_own) : '0;
        e_acc   = (m_own >= 0 && bit_of(drv_req, m_own) && !full_in) ? e_grant : '0;
        e_data  = (m_own >= 0) ? drv_word[m_own] : '0;
        chk("grant",    32'(bus.grant),    32'(e_grant));
        chk("busy",     32'(bus.busy),     (m_own >= 0) ? 32'd1 : 32'd0);
        chk("accept",   32'(bus.accept),   32'(e_acc));
        chk("write_en", 32'(bus.write_en), 32'(|e_acc));
        chk("data_in",  32'(bus.data_in),  32'(e_data));
`ifdef FIFO_ARB_STATS_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
        if (bus.write_en) begin
            who = -1;
            for (int i = 0; i < NUM_REQ; i++) if (bit_of(bus.accept, i)) who = i;
            wr_log.push_back('{cyc, who, bus.data_in});
        end
        if (bus.grant != prev_grant && bus.grant != '0) grant_log.push_back(bus.grant);
        prev_grant = bus.grant;
        @(posedge clk_write);
        if (|e_acc) void'(src_q[m_own].pop_front());
        model_update(rst, drv_req, full_in);
        cyc++;
        @(negedge clk_write);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        grant_log.delete();
        prev_grant = '0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        req_en  = '1;
        full_in = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        rst        = 1'b1;
        req_en     = '1;
        full_in    = 1'b0;
        m_own      = -1;
        m_last     = NUM_REQ - 1;
        m_left     = 0;
        m_stall    = 0;
        prev_grant = '0;
        drive();
        @(posedge clk_write);
        @(negedge clk_write);

        // Reset held with every requester pending
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(WIDTH'(i * 16 + k));
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_first_grant", 32'(bus.grant), 32'h1);

        // Single burst followed by a re-grant to the only requester
        do_reset();
        sb_exp = '{8'hAA, 8'hBB, 8'hCC, 8'h95, 8'h0B};
        for (int k = 0; k < 5; k++) src_q[0].push_back(sb_exp[k]);
        repeat (8) tick();
        chk("sb_nwrites", 32'(wr_log.size()), 32'd5);
        if (wr_log.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("sb_data", 32'(wr_log[k].d), 32'(sb_exp[k]));
                chk("sb_slot", 32'(wr_log[k].cyc - wr_log[0].cyc), 32'(k));
            end
        end

        // Fairness with all four requesters saturating
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(WIDTH'(i * 16 + k));
        repeat (21) tick();
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("fair_ngrants", (grant_log.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        if (grant_log.size() >= 5)
            for (int k = 0; k < 5; k++) chk("fair_grant", 32'(grant_log[k]), 32'(fair_exp[k]));
        chk("fair_nwrites", (wr_log.size() >= 16) ? 32'd1 : 32'd0, 32'd1);
        if (wr_log.size() >= 16) begin
            for (int k = 0; k < 16; k++) begin
                chk("fair_who",  32'(wr_log[k].who), 32'(k / 4));
                chk("fair_slot", 32'(wr_log[k].cyc - wr_log[0].cyc), 32'(k));
            end
        end

        // Backpressure for 3 cycles after the 2nd word
        do_reset();
        src_q[0] = '{8'h11, 8'h22, 8'h33, 8'h44};
        tick();
        tick();
        tick();
        full_in = 1'b1;
        repeat (3) tick();
        full_in = 1'b0;
        repeat (3) tick();
        chk("bp_nwrites", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            chk("bp_slot2", 32'(wr_log[2].cyc - wr_log[0].cyc), 32'd5);
            chk("bp_slot3", 32'(wr_log[3].cyc - wr_log[0].cyc), 32'd6);
            chk("bp_word3", 32'(wr_log[2].d), 32'h33);
        end
`ifdef FIFO_ARB_STATS_EN
        chk("bp_stall", 32'(stall_cycles), 32'd3);
`endif

        // Early release by requester 0 while requester 2 waits
        do_reset();
        src_q[0] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        src_q[2] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        tick();
        tick();
        tick();
        req_en = 4'b1110;
        tick();
        chk("er_grant", 32'(bus.grant), 32'h4);
        repeat (5) tick();
        chk("er_nwrites", 32'(wr_log.size()), 32'd6);
        if (wr_log.size() == 6) begin
            chk("er_dead", 32'(wr_log[2].cyc - wr_log[1].cyc), 32'd2);
            for (int k = 2; k < 6; k++) chk("er_who", 32'(wr_log[k].who), 32'd2);
        end
        req_en = '1;

        // Reset pulsed during requester 1's second word
        do_reset();
        for (int k = 0; k < 4; k++) src_q[1].push_back(WIDTH'(8'h50 + k));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_grant", 32'(bus.grant), 32'h0);
`ifdef FIFO_ARB_STATS_EN
        chk("rm_stall", 32'(stall_cycles), 32'd0);
`endif
        for (int k = 0; k < 4; k++) src_q[0].push_back(WIDTH'(8'h60 + k));
        tick();
        chk("rm_first_grant", 32'(bus.grant), 32'h1);
        repeat (10) tick();

        // Randomised traffic, backpressure, request drops and resets
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 2) == 0 && src_q[i].size() < 6)
                    src_q[i].push_back(WIDTH'($urandom));
                if ($urandom_range(0, 15) == 0) req_en = req_en ^ (NUM_REQ'(1) << i);
            end
            full_in = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst     = 1'b0;
        full_in = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
